// File: rtl/cpu_defs_pkg.sv
// Shared encodings for the MIPS pipeline: write-data select, load types, reset PC.
package cpu_defs;

    localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;

    typedef enum logic [1:0] {
        WD_ALU  = 2'b00,
        WD_LOAD = 2'b01,
        WD_PC8  = 2'b10,
        WD_ZERO = 2'b11
    } wdsel_e;

    // Codes 5..7 are not listed here and decode as a plain word load.
    typedef enum logic [2:0] {
        LD_W  = 3'b000,
        LD_BU = 3'b001,
        LD_B  = 3'b010,
        LD_HU = 3'b011,
        LD_H  = 3'b100
    } loadtype_e;

endpackage

// File: rtl/mem_wb_stage_load_ext.sv
// Load extractor: picks byte/half/word out of the memory word by address,
// extends it, and flags misaligned word/half accesses.
module load_ext
    import cpu_defs::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  addr_i,
    input  logic [2:0]  load_type_i,
    output logic [31:0] data_o,
    output logic        fault_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[7:0];
        case (addr_i)
            2'd0: byte_sel = word_i[7:0];
            2'd1: byte_sel = word_i[15:8];
            2'd2: byte_sel = word_i[23:16];
            2'd3: byte_sel = word_i[31:24];
            default: byte_sel = word_i[7:0];
        endcase
        half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];
    end

    always_comb begin
        data_o  = word_i;
        fault_o = 1'b0;
        case (load_type_i)
            LD_BU: data_o = {24'd0, byte_sel};
            LD_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
            LD_HU: begin
                data_o  = {16'd0, half_sel};
                fault_o = addr_i[0];
            end
            LD_H: begin
                data_o  = {{16{half_sel[15]}}, half_sel};
                fault_o = addr_i[0];
            end
            default: begin
                data_o  = word_i;
                fault_o = (addr_i != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// M->W pipeline register with load extension, write-data select and fault gating.
// Optional retired-instruction counter enabled by defining MEMWB_RETIRE_CNT_EN.
module mem_wb_stage
    import cpu_defs::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic        clr,
    input  logic [31:0] M_ALUResult,
    input  logic [31:0] MEMDataOut,
    input  logic [31:0] M_PC,
    input  logic [4:0]  M_A3,
    input  logic        M_RegWrite,
    input  logic [1:0]  M_WDSel,
    input  logic [2:0]  M_LoadType,
    output logic [31:0] W_PC,
    output logic [4:0]  W_A3,
    output logic        W_RegWrite,
    output logic [31:0] W_WD,
    output logic        W_LoadFault
`ifdef MEMWB_RETIRE_CNT_EN
    ,
    output logic [31:0] W_RetireCnt
`endif
);

    logic [31:0] pc_q;
    logic [4:0]  a3_q;
    logic        regwrite_q;
    wdsel_e      wdsel_q;
    logic [2:0]  loadtype_q;
    logic [31:0] alu_q;
    logic [31:0] memdata_q;

    logic [31:0] load_data;
    logic        load_fault_raw;
    logic        load_fault;

    // Bubble and reset share the same register image.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= PC_RESET;
            a3_q       <= 5'd0;
            regwrite_q <= 1'b0;
            wdsel_q    <= WD_ALU;
            loadtype_q <= 3'd0;
            alu_q      <= 32'd0;
            memdata_q  <= 32'd0;
        end else if (clr) begin
            pc_q       <= PC_RESET;
            a3_q       <= 5'd0;
            regwrite_q <= 1'b0;
            wdsel_q    <= WD_ALU;
            loadtype_q <= 3'd0;
            alu_q      <= 32'd0;
            memdata_q  <= 32'd0;
        end else if (en) begin
            pc_q       <= M_PC;
            a3_q       <= M_A3;
            regwrite_q <= M_RegWrite;
            wdsel_q    <= wdsel_e'(M_WDSel);
            loadtype_q <= M_LoadType;
            alu_q      <= M_ALUResult;
            memdata_q  <= MEMDataOut;
        end
    end

    load_ext u_load_ext (
        .word_i      (memdata_q),
        .addr_i      (alu_q[1:0]),
        .load_type_i (loadtype_q),
        .data_o      (load_data),
        .fault_o     (load_fault_raw)
    );

    // Alignment only matters when the instruction actually writes back load data.
    assign load_fault = load_fault_raw && (wdsel_q == WD_LOAD);

    always_comb begin
        W_WD = 32'd0;
        case (wdsel_q)
            WD_ALU:  W_WD = alu_q;
            WD_LOAD: W_WD = load_fault ? 32'd0 : load_data;
            WD_PC8:  W_WD = pc_q + 32'd8;
            WD_ZERO: W_WD = 32'd0;
            default: W_WD = 32'd0;
        endcase
    end

    assign W_PC        = pc_q;
    assign W_A3        = a3_q;
    assign W_LoadFault = load_fault;
    assign W_RegWrite  = regwrite_q && (a3_q != 5'd0) && !load_fault;

`ifdef MEMWB_RETIRE_CNT_EN
    logic        valid_q;
    logic [31:0] retire_cnt_q;
    logic [31:0] retire_cnt_d;

    // A W instruction retires on the edge that moves it out; held edges do not count.
    always_comb begin
        retire_cnt_d = retire_cnt_q;
        if (en && (W_RegWrite || valid_q)) begin
            retire_cnt_d = retire_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= 1'b0;
            retire_cnt_q <= 32'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
            if (clr) begin
                valid_q <= 1'b0;
            end else if (en) begin
                valid_q <= 1'b1;
            end
        end
    end

    assign W_RetireCnt = retire_cnt_q;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: directed load/select cases, hold/flush,
// asynchronous reset and randomized traffic against an arithmetic reference model.
module tb_mem_wb_stage;

    localparam logic [31:0] PC_RST = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        clr;
    logic [31:0] M_ALUResult;
    logic [31:0] MEMDataOut;
    logic [31:0] M_PC;
    logic [4:0]  M_A3;
    logic        M_RegWrite;
    logic [1:0]  M_WDSel;
    logic [2:0]  M_LoadType;
    logic [31:0] W_PC;
    logic [4:0]  W_A3;
    logic        W_RegWrite;
    logic [31:0] W_WD;
    logic        W_LoadFault;
`ifdef MEMWB_RETIRE_CNT_EN
    logic [31:0] W_RetireCnt;
`endif

    int checks;
    int errors;

    // Reference model: the instruction currently sitting in W (or a bubble).
    bit          m_valid;
    logic [31:0] m_pc;
    logic [4:0]  m_a3;
    logic        m_rw;
    logic [1:0]  m_wdsel;
    logic [2:0]  m_lt;
    logic [31:0] m_alu;
    logic [31:0] m_word;
    logic [31:0] m_cnt;

    logic [31:0] e_pc;
    logic [4:0]  e_a3;
    logic        e_rw;
    logic [31:0] e_wd;
    logic        e_flt;

    mem_wb_stage #(.PC_RESET(PC_RST)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .clr         (clr),
        .M_ALUResult (M_ALUResult),
        .MEMDataOut  (MEMDataOut),
        .M_PC        (M_PC),
        .M_A3        (M_A3),
        .M_RegWrite  (M_RegWrite),
        .M_WDSel     (M_WDSel),
        .M_LoadType  (M_LoadType),
        .W_PC        (W_PC),
        .W_A3        (W_A3),
        .W_RegWrite  (W_RegWrite),
        .W_WD        (W_WD),
        .W_LoadFault (W_LoadFault)
`ifdef MEMWB_RETIRE_CNT_EN
        ,
        .W_RetireCnt (W_RetireCnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_bubble();
        m_valid = 0;
        m_pc = PC_RST; m_a3 = 0; m_rw = 0; m_wdsel = 0; m_lt = 0; m_alu = 0; m_word = 0;
    endtask

    // Expected W outputs, derived from the load/select rules with plain arithmetic.
    task automatic model_expect();
        int unsigned a;
        int unsigned b;
        int unsigned h;
        e_pc = m_pc; e_a3 = m_a3; e_flt = 0; e_wd = 0;
        a = m_alu % 4;
        case (m_wdsel)
            2'd0: e_wd = m_alu;
            2'd2: e_wd = m_pc + 32'd8;
            2'd3: e_wd = 0;
            default: begin
                b = (m_word >> (8 * a)) & 32'hFF;
                h = (m_word >> (16 * (a / 2))) & 32'hFFFF;
                case (m_lt)
                    3'd1: e_wd = b;
                    3'd2: e_wd = (b >= 128) ? b + 32'hFFFF_FF00 : b;
                    3'd3: begin e_wd = h; e_flt = (a % 2) != 0; end
                    3'd4: begin e_wd = (h >= 32768) ? h + 32'hFFFF_0000 : h; e_flt = (a % 2) != 0; end
                    default: begin e_wd = m_word; e_flt = (a != 0); end
                endcase
                if (e_flt) e_wd = 0;
            end
        endcase
        e_rw = m_rw && (m_a3 != 0) && !e_flt;
    endtask

    task automatic model_edge(input logic e, input logic c);
        model_expect();
        if (e && (e_rw || m_valid)) m_cnt = m_cnt + 32'd1;
        if (c) begin
            model_bubble();
        end else if (e) begin
            m_valid = 1; m_pc = M_PC; m_a3 = M_A3; m_rw = M_RegWrite;
            m_wdsel = M_WDSel; m_lt = M_LoadType; m_alu = M_ALUResult; m_word = MEMDataOut;
        end
        model_expect();
    endtask

    task automatic tick(input logic e, input logic c);
        en = e; clr = c;
        @(posedge clk);
        model_edge(e, c);
        #1;
    endtask

    task automatic set_m(input logic [31:0] alu, input logic [31:0] word, input logic [31:0] pc,
                         input logic [4:0] a3, input logic rw, input logic [1:0] wds, input logic [2:0] lt);
        M_ALUResult = alu; MEMDataOut = word; M_PC = pc; M_A3 = a3;
        M_RegWrite = rw; M_WDSel = wds; M_LoadType = lt;
    endtask

    task automatic set_m_random();
        set_m($urandom, $urandom, $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 31)),
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    endtask

    task automatic test_reset();
        en = 0; clr = 0; rst_n = 0;
        set_m(32'h1234_5678, 32'hCAFE_F00D, 32'h0000_4000, 5'd9, 1'b1, 2'b00, 3'd0);
        model_bubble(); m_cnt = 0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (W_PC !== PC_RST || W_A3 !== 5'd0 || W_RegWrite !== 1'b0 || W_WD !== 32'd0 || W_LoadFault !== 1'b0) begin
            errors++;
            $display("FAIL reset_values got pc=%h a3=%0d rw=%b wd=%h flt=%b want pc=%h others 0",
                     W_PC, W_A3, W_RegWrite, W_WD, W_LoadFault, PC_RST);
        end
        #3 rst_n = 1;
        tick(1'b1, 1'b0);
        checks++;
        if (W_PC !== 32'h0000_4000 || W_A3 !== 5'd9 || W_RegWrite !== 1'b1 || W_WD !== 32'h1234_5678) begin
            errors++;
            $display("FAIL reset_release_capture got pc=%h a3=%0d rw=%b wd=%h want pc=00004000 a3=9 rw=1 wd=12345678",
                     W_PC, W_A3, W_RegWrite, W_WD);
        end
    endtask

    typedef struct {
        logic [31:0] alu; logic [31:0] word; logic [31:0] pc; logic [4:0] a3;
        logic rw; logic [1:0] wds; logic [2:0] lt;
        logic [31:0] x_wd; logic x_rw; logic x_flt;
    } vec_t;

    task automatic test_directed();
        vec_t v[9];
        v[0] = '{32'h1003, 32'h80FF_1234, 32'h3000, 5'd2, 1, 2'b01, 3'd2, 32'hFFFF_FF80, 1, 0};
        v[1] = '{32'h1003, 32'h80FF_1234, 32'h3004, 5'd2, 1, 2'b01, 3'd1, 32'h0000_0080, 1, 0};
        v[2] = '{32'h2002, 32'h8001_7FFF, 32'h3008, 5'd3, 1, 2'b01, 3'd4, 32'hFFFF_8001, 1, 0};
        v[3] = '{32'h2000, 32'h8001_7FFF, 32'h300C, 5'd3, 1, 2'b01, 3'd3, 32'h0000_7FFF, 1, 0};
        v[4] = '{32'h0006, 32'hDEAD_BEEF, 32'h3010, 5'd8, 1, 2'b01, 3'd0, 32'h0000_0000, 0, 1};
        v[5] = '{32'h0004, 32'hDEAD_BEEF, 32'h3014, 5'd8, 1, 2'b01, 3'd0, 32'hDEAD_BEEF, 1, 0};
        v[6] = '{32'h0000, 32'h0000_0000, 32'h3010, 5'd31, 1, 2'b10, 3'd0, 32'h0000_3018, 1, 0};
        v[7] = '{32'h0000_0055, 32'h0, 32'h3018, 5'd0, 1, 2'b00, 3'd0, 32'h0000_0055, 0, 0};
        v[8] = '{32'h2001, 32'h1234_5678, 32'h301C, 5'd4, 1, 2'b01, 3'd3, 32'h0000_0000, 0, 1};
        for (int i = 0; i < 9; i++) begin
            set_m(v[i].alu, v[i].word, v[i].pc, v[i].a3, v[i].rw, v[i].wds, v[i].lt);
            tick(1'b1, 1'b0);
            checks++;
            if (W_WD !== v[i].x_wd || W_RegWrite !== v[i].x_rw || W_LoadFault !== v[i].x_flt || W_PC !== v[i].pc) begin
                errors++;
                $display("FAIL directed_%0d got wd=%h rw=%b flt=%b pc=%h want wd=%h rw=%b flt=%b pc=%h", i,
                         W_WD, W_RegWrite, W_LoadFault, W_PC, v[i].x_wd, v[i].x_rw, v[i].x_flt, v[i].pc);
            end
        end
    endtask

    task automatic test_hold();
        set_m(32'hA5A5_0001, 32'h0, 32'h0000_5000, 5'd7, 1'b1, 2'b00, 3'd0);
        tick(1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            set_m_random();
            tick(1'b0, 1'b0);
            checks++;
            if (W_PC !== 32'h0000_5000 || W_A3 !== 5'd7 || W_WD !== 32'hA5A5_0001 || W_RegWrite !== 1'b1) begin
                errors++;
                $display("FAIL hold_%0d got pc=%h a3=%0d wd=%h rw=%b want pc=00005000 a3=7 wd=a5a50001 rw=1",
                         i, W_PC, W_A3, W_WD, W_RegWrite);
            end
        end
    endtask

    task automatic test_clr();
        for (int i = 0; i < 2; i++) begin
            set_m(32'h0000_0123, 32'h0, 32'h0000_6000, 5'd5, 1'b1, 2'b00, 3'd0);
            tick(1'b1, 1'b0);
            set_m_random();
            tick(i == 0 ? 1'b1 : 1'b0, 1'b1);
            checks++;
            if (W_PC !== PC_RST || W_A3 !== 5'd0 || W_RegWrite !== 1'b0 || W_WD !== 32'd0 || W_LoadFault !== 1'b0) begin
                errors++;
                $display("FAIL clr_bubble_en%0d got pc=%h a3=%0d rw=%b wd=%h flt=%b want bubble",
                         (i == 0), W_PC, W_A3, W_RegWrite, W_WD, W_LoadFault);
            end
        end
    endtask

    task automatic test_async_reset();
        set_m(32'h0000_0777, 32'h0, 32'h0000_7000, 5'd12, 1'b1, 2'b00, 3'd0);
        tick(1'b1, 1'b0);
        #2 rst_n = 0;
        #1;
        model_bubble(); m_cnt = 0;
        checks++;
        if (W_PC !== PC_RST || W_RegWrite !== 1'b0 || W_WD !== 32'd0 || W_A3 !== 5'd0) begin
            errors++;
            $display("FAIL async_reset got pc=%h rw=%b wd=%h a3=%0d want pc=%h rw=0 wd=0 a3=0",
                     W_PC, W_RegWrite, W_WD, W_A3, PC_RST);
        end
        #1 rst_n = 1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            set_m_random();
            if ($urandom_range(0, 3) == 0) M_A3 = 5'd0;
            tick(1'($urandom_range(0, 9) < 8), 1'($urandom_range(0, 9) == 0));
            checks++;
            if (W_PC !== e_pc || W_A3 !== e_a3 || W_RegWrite !== e_rw || W_WD !== e_wd || W_LoadFault !== e_flt) begin
                errors++;
                $display("FAIL random_%0d got pc=%h a3=%0d rw=%b wd=%h flt=%b want pc=%h a3=%0d rw=%b wd=%h flt=%b",
                         i, W_PC, W_A3, W_RegWrite, W_WD, W_LoadFault, e_pc, e_a3, e_rw, e_wd, e_flt);
            end
`ifdef MEMWB_RETIRE_CNT_EN
            checks++;
            if (W_RetireCnt !== m_cnt) begin
                errors++;
                $display("FAIL retire_random_%0d got %0d want %0d", i, W_RetireCnt, m_cnt);
            end
`endif
        end
    endtask

`ifdef MEMWB_RETIRE_CNT_EN
    task automatic test_retire();
        rst_n = 0; #1; rst_n = 1;
        model_bubble(); m_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            set_m_random();
            tick(1'b1, 1'b0);
        end
        tick(1'b1, 1'b1);
        checks++;
        if (W_RetireCnt !== 32'd5) begin
            errors++;
            $display("FAIL retire_five got %0d want 5", W_RetireCnt);
        end
        tick(1'b0, 1'b0);
        checks++;
        if (W_RetireCnt !== 32'd5) begin
            errors++;
            $display("FAIL retire_hold got %0d want 5", W_RetireCnt);
        end
    endtask
`endif

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_hold();
        test_clr();
        test_async_reset();
        test_random();
`ifdef MEMWB_RETIRE_CNT_EN
        test_retire();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
